// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable-length SCLK bursts at a runtime
// divide ratio in all four CPOL/CPHA modes, with shift/sample strobes and busy/done.
module spi_sclk_gen #(
   parameter int DIV_W = 8,
   parameter int NB_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             cpol_i,
   input  logic             cpha_i,
   input  logic [NB_W-1:0]  num_bits_i,
   output logic             sclk_o,
   output logic             shift_stb_o,
   output logic             sample_stb_o,
   output logic             busy_o,
   output logic             done_o
);

   // state | meaning
   // IDLE  | sclk follows cpol_i, waiting for a start with num_bits_i != 0
   // RUN   | toggling sclk every div_q+1 cycles until 2*num_bits edges are out
   // TAIL  | sclk parked at cpol_q for div_q+1 cycles, then done
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TAIL} state_t;

   state_t           state_q,  state_d;
   logic [DIV_W-1:0] hcnt_q,   hcnt_d;
   logic [NB_W:0]    ecnt_q,   ecnt_d;
   logic [DIV_W-1:0] div_q,    div_d;
   logic [NB_W-1:0]  nb_q,     nb_d;
   logic             cpol_q,   cpol_d;
   logic             cpha_q,   cpha_d;
   logic             sclk_q,   sclk_d;
   logic             shift_q,  shift_d;
   logic             sample_q, sample_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic [NB_W:0]    last_idx;
   logic             hc_wrap;
   logic             leading;

   // ecnt_q counts edges already produced, so the edge about to fire is ecnt_q+1
   assign last_idx = {nb_q, 1'b0} - (NB_W+1)'(1);
   assign hc_wrap  = (hcnt_q == div_q);
   assign leading  = ~ecnt_q[0];

   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      ecnt_d   = ecnt_q;
      div_d    = div_q;
      nb_d     = nb_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      sclk_d   = sclk_q;
      busy_d   = busy_q;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sclk_d = cpol_i;
            busy_d = 1'b0;
            if (start_i && (num_bits_i != '0)) begin
               div_d   = div_i;
               nb_d    = num_bits_i;
               cpol_d  = cpol_i;
               cpha_d  = cpha_i;
               hcnt_d  = '0;
               ecnt_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (hc_wrap) begin
               hcnt_d = '0;
               sclk_d = ~sclk_q;
               ecnt_d = ecnt_q + (NB_W+1)'(1);
               if (cpha_q) begin
                  shift_d  = leading;
                  sample_d = ~leading;
               end else begin
                  sample_d = leading;
                  shift_d  = ~leading && (ecnt_q != last_idx);
               end
               if (ecnt_q == last_idx) state_d = ST_TAIL;
            end else begin
               hcnt_d = hcnt_q + DIV_W'(1);
            end
         end
         ST_TAIL: begin
            if (hc_wrap) begin
               hcnt_d  = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               hcnt_d = hcnt_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= '0;
         ecnt_q   <= '0;
         div_q    <= '0;
         nb_q     <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         sclk_q   <= 1'b0;
         shift_q  <= 1'b0;
         sample_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         ecnt_q   <= ecnt_d;
         div_q    <= div_d;
         nb_q     <= nb_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         sclk_q   <= sclk_d;
         shift_q  <= shift_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sclk_o       = sclk_q;
   assign shift_stb_o  = shift_q;
   assign sample_stb_o = sample_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: a burst-level reference model predicts every output each
// cycle into a queue; a negedge monitor pops and compares.
module tb_spi_sclk_gen;

   localparam int DIV_W = 8;
   localparam int NB_W  = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic [DIV_W-1:0] div_i;
   logic             cpol_i;
   logic             cpha_i;
   logic [NB_W-1:0]  num_bits_i;
   logic             sclk_o, shift_stb_o, sample_stb_o, busy_o, done_o;

   spi_sclk_gen #(.DIV_W(DIV_W), .NB_W(NB_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .div_i       (div_i),
      .cpol_i      (cpol_i),
      .cpha_i      (cpha_i),
      .num_bits_i  (num_bits_i),
      .sclk_o      (sclk_o),
      .shift_stb_o (shift_stb_o),
      .sample_stb_o(sample_stb_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   // expected {sclk, shift, sample, busy, done} for the cycle after each edge
   logic [4:0] exp_q[$];
   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   // reference model: time since accept, measured in clk edges
   bit m_busy = 0;
   int m_t, m_d, m_n;
   bit m_cpol, m_cpha;

   always @(posedge clk) begin
      logic [4:0] e;
      int total, k, edges;
      bit lead;
      cyc++;
      e = '0;
      if (rst) begin
         m_busy = 0;
      end else if (m_busy) begin
         m_t++;
         total = (2*m_n + 1) * (m_d + 1);
         if (m_t >= total) begin
            m_busy = 0;
            e = {m_cpol, 1'b0, 1'b0, 1'b0, 1'b1};
         end else begin
            edges = m_t / (m_d + 1);
            if (edges > 2*m_n) edges = 2*m_n;
            e[4] = m_cpol ^ edges[0];
            e[1] = 1'b1;
            if ((m_t % (m_d + 1)) == 0 && (m_t / (m_d + 1)) <= 2*m_n) begin
               k    = m_t / (m_d + 1);
               lead = (k % 2) == 1;
               if (m_cpha) begin
                  e[3] = lead;
                  e[2] = !lead;
               end else begin
                  e[2] = lead;
                  e[3] = !lead && (k != 2*m_n);
               end
            end
         end
      end else if (start_i && num_bits_i != 0) begin
         m_busy = 1;
         m_t    = 0;
         m_d    = int'(div_i);
         m_n    = int'(num_bits_i);
         m_cpol = cpol_i;
         m_cpha = cpha_i;
         e      = {cpol_i, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
         e[4] = cpol_i;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      logic [4:0] e, got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {sclk_o, shift_stb_o, sample_stb_o, busy_o, done_o};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL outputs cyc %0d {sclk,shift,sample,busy,done} got %b expected %b",
                     cyc, got, e);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic burst(input bit pol, input bit pha, input int d, input int n, input int wait_cyc);
      cpol_i = pol; cpha_i = pha; div_i = DIV_W'(d); num_bits_i = NB_W'(n);
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      step(wait_cyc);
   endtask

   task automatic burst_wait(input bit pol, input bit pha, input int d, input int n,
                             input int limit, input int idle_cyc);
      bit seen;
      cpol_i = pol; cpha_i = pha; div_i = DIV_W'(d); num_bits_i = NB_W'(n);
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         step(1);
         if (done_o === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         miscompares++;
         $display("FAIL timeout: done_o not seen within %0d cycles (cyc %0d)", limit, cyc);
      end
      step(idle_cyc);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; div_i = '0; cpol_i = 1'b0; cpha_i = 1'b0; num_bits_i = '0;
      step(3);
      if ({sclk_o, shift_stb_o, sample_stb_o, busy_o, done_o} !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset state: {sclk,shift,sample,busy,done} got %b expected 00000",
                  {sclk_o, shift_stb_o, sample_stb_o, busy_o, done_o});
      end
      rst = 1'b0;
      step(2);

      burst_wait(1'b0, 1'b0, 1, 8, 40, 3);
      burst(1'b1, 1'b1, 0, 1, 6);

      // re-pulse start and change div mid-burst; both must be ignored
      cpol_i = 1'b0; cpha_i = 1'b1; div_i = 8'd3; num_bits_i = 6'd2; start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      step(4);
      start_i = 1'b1; div_i = 8'd0; num_bits_i = 6'd9;
      step(1);
      start_i = 1'b0;
      step(25);

      // zero-length request
      num_bits_i = '0; cpol_i = 1'b1; start_i = 1'b1;
      step(3);
      start_i = 1'b0; cpol_i = 1'b0;
      step(3);

      // reset mid-burst, then a full burst
      cpol_i = 1'b0; cpha_i = 1'b0; div_i = 8'd1; num_bits_i = 6'd8; start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      burst_wait(1'b0, 1'b0, 1, 8, 40, 3);

      // back-to-back bursts with start held, cpol changed between them
      cpol_i = 1'b0; cpha_i = 1'b0; div_i = 8'd0; num_bits_i = 6'd3; start_i = 1'b1;
      step(1);
      cpol_i = 1'b1;
      step(10);
      start_i = 1'b0;
      step(12);

      // maximum-length bursts
      burst(1'b0, 1'b1, 0, 63, 135);
      burst(1'b1, 1'b0, 2, 63, 390);

      // randomized traffic with inputs churning while busy
      for (int c = 0; c < 20000; c++) begin
         rst     = ($urandom_range(0, 1999) == 0);
         start_i = ($urandom_range(0, 3) == 0);
         cpol_i  = 1'($urandom_range(0, 1));
         cpha_i  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            div_i      = DIV_W'($urandom_range(0, 255));
            num_bits_i = NB_W'($urandom_range(0, 2));
         end else begin
            div_i      = DIV_W'($urandom_range(0, 15));
            num_bits_i = ($urandom_range(0, 7) == 0) ? '0 : NB_W'($urandom_range(1, 63));
         end
         step(1);
      end
      rst = 1'b0; start_i = 1'b0;
      step(2);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares == 0) $display("PASS");
      else                  $display("FAIL");
      $finish;
   end

endmodule
